// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the round-robin AXI-Stream arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no grant, GRANT = passthrough)
//   idx_width() : width of a requester index, never less than 1 bit
//   MAX_NUM_S   : largest supported number of requesters
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  localparam int MAX_NUM_S = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// -----------------------------------------------------------------------------
// axis_rr_pick
// Combinational rotating first-one finder. Starting at (last_ptr+1) mod NUM_S
// and wrapping upward, returns the index of the first asserted request.
// Ports:
//   req      in  NUM_S  request vector
//   last_ptr in  IW     index granted most recently (lowest priority now)
//   idx      out IW     winning index (0 when no request)
//   any      out 1      at least one request is set
// -----------------------------------------------------------------------------
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_S = 4
) (
  input  logic [NUM_S-1:0]                req,
  input  logic [idx_width(NUM_S)-1:0]     last_ptr,
  output logic [idx_width(NUM_S)-1:0]     idx,
  output logic                            any
);

  localparam int IW = idx_width(NUM_S);

  logic [IW-1:0] cand;

  // Walk the candidates from the farthest (last_ptr+NUM_S, i.e. last_ptr
  // itself) down to the nearest (last_ptr+1); the last hit written is the
  // closest one after last_ptr, which is the round-robin winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_S; k >= 1; k--) begin
      cand = IW'((int'(last_ptr) + k) % NUM_S);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_arbiter_rr.sv
// -----------------------------------------------------------------------------
// axis_arbiter_rr
// N:1 round-robin AXI-Stream arbiter. In IDLE it picks the next requester
// (one bubble cycle), then in GRANT passes that requester's stream through
// for up to BURST_LEN beats, or until it deasserts tvalid, and rotates.
// Ports:
//   aclk, aresetn    clock, asynchronous active-low reset
//   s_axis_tdata     NUM_S*AXI_DATA_WIDTH flattened requester data (slice i)
//   s_axis_tvalid    NUM_S per-requester valid
//   s_axis_tready    NUM_S per-requester ready (only the granted one can be 1)
//   m_axis_tdata     AXI_DATA_WIDTH arbitrated data
//   m_axis_tvalid    arbitrated valid
//   m_axis_tready    downstream ready
//   m_axis_tid       granted index, 0 in IDLE (only with AXIS_ARB_TID_EN)
// Optional feature macro: AXIS_ARB_TID_EN adds the m_axis_tid output.
// -----------------------------------------------------------------------------
module axis_arbiter_rr
  import axis_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_S          = 4,
  parameter int BURST_LEN      = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_S*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_S-1:0]                s_axis_tvalid,
  output logic [NUM_S-1:0]                s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [idx_width(NUM_S)-1:0]     m_axis_tid
`endif
);

  localparam int            IW        = idx_width(NUM_S);
  localparam int            CW        = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          beat;

  axis_rr_pick #(
    .NUM_S (NUM_S)
  ) u_pick (
    .req      (s_axis_tvalid),
    .last_ptr (last_ptr_q),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Datapath: pure passthrough from the granted requester; everything is
  // quiet while IDLE, which produces the arbitration bubble.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == GRANT) begin
      m_axis_tdata           = s_axis_tdata[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign beat = m_axis_tvalid & m_axis_tready;

`ifdef AXIS_ARB_TID_EN
  assign m_axis_tid = (state_q == GRANT) ? grant_q : '0;
`endif

  // Next-state logic. The winner is only ever chosen in IDLE, so a burst that
  // ends with other requests pending always costs one bubble cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!s_axis_tvalid[grant_q]) begin
          // Requester ran dry: release early.
          state_d    = IDLE;
          last_ptr_d = grant_q;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            last_ptr_d = grant_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= IW'(NUM_S - 1);
      beat_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
